// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator sequencer
package calc_pkg;

   localparam int unsigned CALC_IN_WIDTH  = 4;
   localparam int unsigned CALC_RES_WIDTH = 9;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_DIV = 2'd2,
      OP_MUL = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      S_FIRST  = 2'd0,
      S_SECOND = 2'd1,
      S_OP     = 2'd2,
      S_BUSY   = 2'd3
   } state_t;

   localparam logic [2:0] LED_FIRST  = 3'b001;
   localparam logic [2:0] LED_SECOND = 3'b010;
   localparam logic [2:0] LED_OP     = 3'b100;

   // Operation keys ordered {mul, div, sub, plus}; plus wins when several fire together.
   function automatic op_t pick_op(input logic [3:0] op_acc);
      if (op_acc[0])      return OP_ADD;
      else if (op_acc[1]) return OP_SUB;
      else if (op_acc[2]) return OP_DIV;
      else                return OP_MUL;
   endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - operand/start/done handshake between sequencer and ALU
interface calc_sequencer_if #(
   parameter int unsigned IN_WIDTH  = calc_pkg::CALC_IN_WIDTH,
   parameter int unsigned RES_WIDTH = calc_pkg::CALC_RES_WIDTH
);
   import calc_pkg::*;

   logic [IN_WIDTH-1:0]  alu_a;
   logic [IN_WIDTH-1:0]  alu_b;
   op_t                  alu_op;
   logic                 alu_start;
   logic                 alu_done;
   logic [RES_WIDTH-1:0] alu_result;
   logic                 alu_div_zero;

   modport master (
      output alu_a, alu_b, alu_op, alu_start,
      input  alu_done, alu_result, alu_div_zero
   );

   modport slave (
      input  alu_a, alu_b, alu_op, alu_start,
      output alu_done, alu_result, alu_div_zero
   );

endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - key sync, optional debounce (CALC_DEBOUNCE_EN) and rising-edge accept pulse
module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   output logic accept_o
);

   logic sync1_q, sync2_q;
   logic stable;
   logic prev_q, accept_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef CALC_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   // Any sample matching the current stable level restarts the count, so short glitches die out.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) stable_d = sync2_q;
         else                   cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;
`else
   assign stable = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= 1'b0;
         accept_q <= 1'b0;
      end else begin
         prev_q   <= stable;
         accept_q <= stable & ~prev_q;
      end
   end

   assign accept_o = accept_q;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator key/operand/ALU sequencer; CALC_DEBOUNCE_EN enables key debounce
module calc_sequencer #(
   parameter int unsigned IN_WIDTH        = calc_pkg::CALC_IN_WIDTH,
   parameter int unsigned RES_WIDTH       = calc_pkg::CALC_RES_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = 10000,
   parameter int unsigned ALU_TIMEOUT     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  in_number,
   input  logic                 k_1,
   input  logic                 k_2,
   input  logic                 plus_key,
   input  logic                 substract_key,
   input  logic                 devide_key,
   input  logic                 multiply_key,
   calc_sequencer_if.master     alu,
   output logic [RES_WIDTH-1:0] result,
   output logic                 result_valid,
   output logic                 error,
   output logic [2:0]           led
);
   import calc_pkg::*;

   localparam int unsigned TMR_W = $clog2(ALU_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALU_TIMEOUT - 1);

   logic [5:0] key_raw, key_acc;

   assign key_raw = {multiply_key, devide_key, substract_key, plus_key, k_2, k_1};

   for (genvar i = 0; i < 6; i++) begin : g_key
`ifdef CALC_DEBOUNCE_EN
      key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
`else
      key_conditioner u_cond (
`endif
         .clk      (clk),
         .rst      (rst),
         .key_i    (key_raw[i]),
         .accept_o (key_acc[i])
      );
   end

   state_t               state_q, state_d;
   logic [IN_WIDTH-1:0]  a_q, a_d, b_q, b_d;
   op_t                  op_q, op_d;
   logic                 start_q, start_d;
   logic [RES_WIDTH-1:0] result_q, result_d;
   logic                 valid_q, valid_d;
   logic                 error_q, error_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FIRST;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_ADD;
         start_q  <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         tmr_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         start_q  <= start_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         tmr_q    <= tmr_d;
      end
   end

   // In BUSY every key accept is dropped; done is ignored in the start cycle itself.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      start_d  = 1'b0;
      result_d = result_q;
      valid_d  = 1'b0;
      error_d  = error_q;
      tmr_d    = tmr_q;
      case (state_q)
         S_BUSY: begin
            tmr_d = tmr_q + 1'b1;
            if (alu.alu_done && !start_q) begin
               result_d = alu.alu_result;
               error_d  = alu.alu_div_zero;
               valid_d  = 1'b1;
               state_d  = S_FIRST;
            end else if (tmr_q == TMR_LAST) begin
               result_d = '0;
               error_d  = 1'b1;
               valid_d  = 1'b1;
               state_d  = S_FIRST;
            end
         end
         default: begin
            if (key_acc[0]) begin
               a_d     = in_number;
               state_d = S_SECOND;
            end else if (key_acc[1]) begin
               b_d     = in_number;
               state_d = S_OP;
            end else if (state_q == S_OP && |key_acc[5:2]) begin
               op_d    = pick_op(key_acc[5:2]);
               start_d = 1'b1;
               tmr_d   = '0;
               state_d = S_BUSY;
            end
         end
      endcase
   end

   always_comb begin
      led = LED_FIRST;
      case (state_q)
         S_SECOND:     led = LED_SECOND;
         S_OP, S_BUSY: led = LED_OP;
         default:      led = LED_FIRST;
      endcase
   end

   assign alu.alu_a     = a_q;
   assign alu.alu_b     = b_q;
   assign alu.alu_op    = op_q;
   assign alu.alu_start = start_q;
   assign result        = result_q;
   assign result_valid  = valid_q;
   assign error         = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer with a reference model and ALU model
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int IW  = 4;
   localparam int RW  = 9;
   localparam int DEB = 4;
   localparam int TO  = 8;
`ifdef CALC_DEBOUNCE_EN
   localparam int LAT = DEB + 3;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] in_number;
   logic [5:0]    keys;
   logic [RW-1:0] result;
   logic          result_valid, error;
   logic [2:0]    led;

   int checks = 0;
   int errors = 0;

   // Reference model: what the operator has entered so far.
   int m_a, m_b, m_op, m_stage;

   int alu_delay = 3;
   bit alu_never = 1'b0;
   int alu_cnt   = 0;

   calc_sequencer_if #(.IN_WIDTH(IW), .RES_WIDTH(RW)) alu ();

   calc_sequencer #(
      .IN_WIDTH(IW), .RES_WIDTH(RW), .DEBOUNCE_CYCLES(DEB), .ALU_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .in_number(in_number),
      .k_1(keys[0]), .k_2(keys[1]), .plus_key(keys[2]), .substract_key(keys[3]),
      .devide_key(keys[4]), .multiply_key(keys[5]),
      .alu(alu),
      .result(result), .result_valid(result_valid), .error(error), .led(led)
   );

   always #5 clk = ~clk;

   initial begin
      int sa, sb, r;
      alu.alu_done     = 1'b0;
      alu.alu_result   = '0;
      alu.alu_div_zero = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         alu.alu_done     = 1'b0;
         alu.alu_div_zero = 1'b0;
         if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
               sa = int'(alu.alu_a);
               sb = int'(alu.alu_b);
               case (alu.alu_op)
                  OP_ADD: r = sa + sb;
                  OP_SUB: r = sa - sb;
                  OP_DIV: if (sb == 0) begin r = 0; alu.alu_div_zero = 1'b1; end else r = sa / sb;
                  default: r = sa * sb;
               endcase
               alu.alu_result = RW'(r);
               alu.alu_done   = 1'b1;
            end
         end
         if (alu.alu_start === 1'b1 && !alu_never) alu_cnt = alu_delay;
      end
   end

   function automatic logic [2:0] led_of(input int s);
      return 3'(1 << s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [5:0] mask, input logic [IW-1:0] num, input string name);
      int sel, exp_stage, exp_off, off, pulses, exp_r;
      bit op_go, exp_e;
      logic [2:0] led0;
      logic [RW-1:0] r_seen;
      logic e_seen;
      sel = -1;
      for (int i = 0; i < 6; i++) if (mask[i] && sel < 0) sel = i;
      led0 = led;
      exp_stage = m_stage;
      op_go = 1'b0;
      if (sel == 0) begin m_a = int'(num); exp_stage = 1; end
      else if (sel == 1) begin m_b = int'(num); exp_stage = 2; end
      else if (sel >= 2 && m_stage == 2) begin m_op = sel - 2; op_go = 1'b1; end
      in_number = num;
      keys = mask;
      repeat (LAT) tick();
      checks++;
      if (led !== led0) begin errors++; $display("FAIL %s early_led: got %b expected %b", name, led, led0); end
      tick();
      checks++;
      if (led !== (op_go ? LED_OP : led_of(exp_stage))) begin
         errors++; $display("FAIL %s led: got %b expected %b", name, led, op_go ? LED_OP : led_of(exp_stage));
      end
      checks++;
      if (alu.alu_a !== IW'(m_a) || alu.alu_b !== IW'(m_b)) begin
         errors++; $display("FAIL %s operands: got a=%0d b=%0d expected a=%0d b=%0d", name, alu.alu_a, alu.alu_b, m_a, m_b);
      end
      checks++;
      if (alu.alu_start !== op_go) begin errors++; $display("FAIL %s alu_start: got %b expected %b", name, alu.alu_start, op_go); end
      if (op_go) begin
         checks++;
         if (alu.alu_op !== op_t'(m_op)) begin errors++; $display("FAIL %s alu_op: got %0d expected %0d", name, alu.alu_op, m_op); end
         exp_off = alu_never ? TO : alu_delay + 1;
         case (m_op)
            0: exp_r = m_a + m_b;
            1: exp_r = m_a - m_b;
            2: exp_r = (m_b == 0) ? 0 : m_a / m_b;
            default: exp_r = m_a * m_b;
         endcase
         exp_e = (m_op == 2 && m_b == 0);
         if (alu_never) begin exp_r = 0; exp_e = 1'b1; end
         pulses = 0;
         off = -1;
         r_seen = '0;
         e_seen = 1'b0;
         for (int c = 1; c <= TO + 4; c++) begin
            tick();
            if (c == 1) begin
               checks++;
               if (alu.alu_start !== 1'b0) begin errors++; $display("FAIL %s start_pulse: got %b expected 0", name, alu.alu_start); end
            end
            if (result_valid === 1'b1) begin
               pulses++;
               if (off < 0) begin
                  off = c; r_seen = result; e_seen = error;
                  checks++;
                  if (led !== LED_FIRST) begin errors++; $display("FAIL %s led_done: got %b expected 001", name, led); end
               end
            end
         end
         checks++;
         if (off != exp_off || pulses != 1) begin
            errors++; $display("FAIL %s result_timing: got cycle %0d pulses %0d expected cycle %0d pulses 1", name, off, pulses, exp_off);
         end
         checks++;
         if (r_seen !== RW'(exp_r) || e_seen !== exp_e) begin
            errors++; $display("FAIL %s result: got %0d err %b expected %0d err %b", name, $signed(r_seen), e_seen, exp_r, exp_e);
         end
         exp_stage = 0;
      end
      m_stage = exp_stage;
      keys = '0;
      repeat (LAT + 2) tick();
      checks++;
      if (led !== led_of(m_stage) || result_valid !== 1'b0) begin
         errors++; $display("FAIL %s settle: got led %b valid %b expected %b 0", name, led, result_valid, led_of(m_stage));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; keys = '0; in_number = '0;
      repeat (2) tick();
      rst = 1'b0;
      m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
      checks++;
      if (led !== LED_FIRST || result !== '0 || error !== 1'b0 || alu.alu_start !== 1'b0 || result_valid !== 1'b0) begin
         errors++; $display("FAIL reset: got led %b res %0d err %b start %b valid %b expected 001 0 0 0 0", led, result, error, alu.alu_start, result_valid);
      end
      checks++;
      if (alu.alu_a !== '0 || alu.alu_b !== '0 || alu.alu_op !== OP_ADD) begin
         errors++; $display("FAIL reset_alu: got a %0d b %0d op %0d expected 0 0 0", alu.alu_a, alu.alu_b, alu.alu_op);
      end
   endtask

   task automatic test_basic();
      alu_never = 1'b0; alu_delay = 3;
      press(6'b000001, 4'd7, "basic_k1");
      press(6'b000010, 4'd9, "basic_k2");
      press(6'b000100, 4'd0, "basic_plus");
   endtask

   task automatic test_div_zero();
      press(6'b000001, 4'd5, "div_k1");
      press(6'b000010, 4'd0, "div_k2");
      press(6'b010000, 4'd0, "div_zero");
      press(6'b000010, 4'd3, "div_k2b");
      press(6'b000100, 4'd0, "div_clear");
   endtask

   task automatic test_reuse();
      press(6'b000010, 4'd3, "reuse_k2");
      press(6'b100000, 4'd0, "reuse_mul");
   endtask

   task automatic test_glitch();
`ifdef CALC_DEBOUNCE_EN
      logic [2:0] led0;
      led0 = led;
      in_number = 4'd12;
      keys = 6'b000001;
      repeat (3) tick();
      keys = '0;
      repeat (LAT + 4) tick();
      checks++;
      if (led !== led0 || alu.alu_a !== IW'(m_a)) begin
         errors++; $display("FAIL glitch: got led %b a %0d expected %b %0d", led, alu.alu_a, led0, m_a);
      end
`endif
   endtask

   task automatic test_simultaneous();
      press(6'b000010, 4'd4, "simul_k2");
      press(6'b000101, 4'd6, "simul_k1_plus");
      press(6'b001010, 4'd2, "simul_k2_sub");
      press(6'b101000, 4'd0, "simul_sub_mul");
   endtask

   task automatic test_busy_keys();
      press(6'b000010, 4'd1, "busy_k2");
      alu_never = 1'b1;
      in_number = 4'd0;
      keys = 6'b000100;
      repeat (LAT + 1) tick();
      checks++;
      if (alu.alu_start !== 1'b1) begin errors++; $display("FAIL busy_start: got %b expected 1", alu.alu_start); end
      in_number = 4'd15;
      keys = 6'b000111;
      for (int c = 1; c <= TO + 2; c++) begin
         tick();
         if (c == LAT) begin
            checks++;
            if (led !== LED_OP) begin errors++; $display("FAIL busy_hold: got led %b expected 100", led); end
         end
      end
      repeat (LAT + 2) tick();
      checks++;
      if (led !== LED_FIRST || alu.alu_a !== IW'(m_a) || error !== 1'b1) begin
         errors++; $display("FAIL busy_drop: got led %b a %0d err %b expected 001 %0d 1", led, alu.alu_a, error, m_a);
      end
      keys = '0;
      m_stage = 0;
      repeat (LAT + 2) tick();
      alu_never = 1'b0;
   endtask

   task automatic test_timeout();
      press(6'b000010, 4'd2, "to_k2");
      alu_never = 1'b1;
      press(6'b001000, 4'd0, "timeout");
      alu_never = 1'b0;
   endtask

   task automatic test_reset_mid_busy();
      int pulses;
      press(6'b000010, 4'd5, "rb_k2");
      alu_never = 1'b1;
      keys = 6'b000100;
      repeat (LAT + 1) tick();
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      m_a = 0; m_b = 0; m_op = 0; m_stage = 0;
      alu_never = 1'b0;
      alu_cnt = 2;
      pulses = 0;
      for (int c = 0; c < TO + LAT + 4; c++) begin
         tick();
         if (result_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || led !== LED_FIRST || result !== '0 || error !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got pulses %0d led %b res %0d err %b expected 0 001 0 0", pulses, led, result, error);
      end
      keys = '0;
      repeat (LAT + 2) tick();
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 1) == 1 || m_stage != 0) press(6'b000001, 4'($urandom), "rand_k1");
         if ($urandom_range(0, 2) == 0) press(6'(4 << $urandom_range(0, 3)), 4'd0, "rand_ignored_op");
         press(6'b000010, 4'($urandom), "rand_k2");
         alu_delay = $urandom_range(1, 7);
         alu_never = ($urandom_range(0, 5) == 0);
         press(6'(4 << $urandom_range(0, 3)), 4'd0, "rand_op");
         alu_never = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_reuse();
      test_glitch();
      test_simultaneous();
      test_busy_keys();
      test_timeout();
      test_reset_mid_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
